// File: rtl/uart.sv
// Full-duplex UART: independent TX and RX engines sharing one bit-period setting.
// Frame format is start(0), BITS_PER_WORD data bits LSB first, stop(1).
module uart #(
  parameter int CLOCKS_PER_PULSE = 10,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  input  logic [BITS_PER_WORD-1:0] s_data,
  output logic                     s_ready,
  output logic                     tx,
  input  logic                     rx,
  output logic                     m_valid,
  output logic [BITS_PER_WORD-1:0] m_data
);

  localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
  localparam int BIT_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_WORD - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  // ---------------- transmitter ----------------
  logic [1:0]               tx_state_q, tx_state_d;
  logic [CNT_W-1:0]         tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]         tx_bit_q, tx_bit_d;
  logic [BITS_PER_WORD-1:0] tx_shift_q, tx_shift_d;
  logic                     tx_q, tx_d;
  logic                     s_ready_q, s_ready_d;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    s_ready_d  = s_ready_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d      = 1'b1;
        s_ready_d = 1'b1;
        tx_cnt_d  = '0;
        // s_ready_q is low for the first cycle out of reset, so no word is taken then.
        if (s_valid && s_ready_q) begin
          tx_shift_d = s_data;
          tx_d       = 1'b0;
          s_ready_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          s_ready_d  = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rstn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      s_ready_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign tx      = tx_q;
  assign s_ready = s_ready_q;

  // ---------------- receiver ----------------
  logic                     rx_meta_q, rx_sync_q;
  logic [2:0]               rx_state_q, rx_state_d;
  logic [CNT_W-1:0]         rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]         rx_bit_q, rx_bit_d;
  logic [BITS_PER_WORD-1:0] rx_shift_q, rx_shift_d;
  logic [BITS_PER_WORD-1:0] m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    m_data_d   = m_data_q;
    m_valid_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid-start-bit recheck rejects short low glitches.
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d                  = '0;
          rx_shift_d                = rx_shift_q >> 1;
          rx_shift_d[BITS_PER_WORD-1] = rx_sync_q;
          if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            m_data_d   = rx_shift_q;
            m_valid_d  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: TX bit timing, loopback, held s_valid, RX glitch,
// framing error and mid-frame reset, all with CLOCKS_PER_PULSE=10, 8-bit words.
module tb_uart;

  logic       clk = 1'b0;
  logic       rstn;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       tx;
  logic       rx;
  logic       m_valid;
  logic [7:0] m_data;
  logic       rx_drv;
  logic       loop_en;

  int errors = 0;
  int checks = 0;
  int mv_count;
  int mv_k;
  logic [7:0] mv_data;
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  assign rx = loop_en ? tx : rx_drv;

  uart #(.CLOCKS_PER_PULSE(10), .BITS_PER_WORD(8)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .tx(tx), .rx(rx), .m_valid(m_valid), .m_data(m_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hold_val(input int c);
    return 8'(c * 13 + 5);
  endfunction

  // Returns at a falling edge where s_ready is high.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check(tag, 32'(s_ready), 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ready("send_ready_timeout");
    s_valid = 1'b1;
    s_data  = b;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = ~b;
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (m_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(m_valid), 1);
    check({tag, "_data"}, 32'(m_data), 32'(b));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(m_valid), 0);
  endtask

  // Drives rx_drv for n cycles while counting m_valid pulses.
  task automatic rx_hold(input logic v, input int n);
    rx_drv = v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        mv_count++;
        mv_data = m_data;
      end
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    rx_hold(1'b0, 10);
    for (int i = 0; i < 8; i++) rx_hold(d[i], 10);
    rx_hold(stop, 10);
    rx_hold(1'b1, 20);
  endtask

  initial begin
    logic [7:0] tv;
    logic       exp_tx;
    int         accept[3];

    rstn    = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    rx_drv  = 1'b1;
    loop_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_mvalid", 32'(m_valid), 0);
    check("rst_mdata", 32'(m_data), 0);

    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 32'(s_ready), 1);
    check("tx_idle", 32'(tx), 1);

    // TX bit timing for 0xA5 with s_data scrambled after acceptance
    tv       = 8'hA5;
    s_valid  = 1'b1;
    s_data   = tv;
    @(posedge clk);
    #1;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    mv_count = 0;
    mv_k     = -1;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k < 10)      exp_tx = 1'b0;
      else if (k < 90) exp_tx = tv[(k - 10) / 10];
      else             exp_tx = 1'b1;
      check("tx_bit", 32'(tx), 32'(exp_tx));
      check("tx_ready", 32'(s_ready), (k < 100) ? 0 : 1);
      if (m_valid === 1'b1) begin
        mv_count++;
        mv_k    = k;
        mv_data = m_data;
      end
    end
    check("a5_pulses", mv_count, 1);
    check("a5_data", 32'(mv_data), 32'h00A5);
    check("a5_latency", 32'(mv_k >= 95 && mv_k <= 99), 1);

    // Loopback sequence
    send_byte(8'hA5); expect_rx("lb_a5", 8'hA5);
    send_byte(8'h3C); expect_rx("lb_3c", 8'h3C);
    send_byte(8'hF0); expect_rx("lb_f0", 8'hF0);

    // s_valid held high with s_data changing every cycle
    accept = '{0, 101, 202};
    wait_ready("hold_ready_timeout");
    for (int c = 0; c <= 320; c++) begin
      s_valid = (c < 250);
      s_data  = hold_val(c);
      @(posedge clk);
      @(negedge clk);
      if (m_valid === 1'b1) rxq.push_back(m_data);
    end
    s_valid = 1'b0;
    check("hold_count", rxq.size(), 3);
    for (int i = 0; i < 3; i++)
      check("hold_data", (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD, 32'(hold_val(accept[i])));

    // RX glitch rejection then a clean frame
    loop_en  = 1'b0;
    mv_count = 0;
    rx_hold(1'b0, 3);
    rx_hold(1'b1, 30);
    check("glitch_no_valid", mv_count, 0);
    rx_frame(8'h5A, 1'b1);
    check("rx5a_count", mv_count, 1);
    check("rx5a_data", 32'(m_data), 32'h005A);

    // Framing error keeps old data, next good frame lands
    mv_count = 0;
    rx_frame(8'h81, 1'b0);
    check("ferr_no_valid", mv_count, 0);
    check("ferr_hold", 32'(m_data), 32'h005A);
    rx_frame(8'h42, 1'b1);
    check("rx42_count", mv_count, 1);
    check("rx42_data", 32'(m_data), 32'h0042);

    // One-cycle reset in the middle of a loopback frame
    loop_en = 1'b1;
    send_byte(8'h99);
    repeat (40) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", 32'(tx), 1);
    check("midrst_mvalid", 32'(m_valid), 0);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", 32'(s_ready), 1);
    check("midrst_tx_idle", 32'(tx), 1);
    mv_count = 0;
    rx_hold(1'b1, 120);
    check("midrst_no_valid", mv_count, 0);
    check("midrst_mdata", 32'(m_data), 0);
    send_byte(8'h3C);
    expect_rx("post_rst_3c", 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
